ma_mem_access_ctrl: RTL and testbench

// - Sequences the Memory Access (MA) stage. Sits between the EX/MA pipeline register outputs and a multi-cycle data memory.
// - Converts mem_read/mem_write/func_3/address into a req/ack memory transaction with byte enables and replicated store data.
// - Stalls the pipeline while a transaction is in flight.
// - Returns load data with RV32 sign/zero extension.

---
 rtl/ma_mem_access_ctrl_if.sv | 20 ++
 rtl/ma_mem_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_ma_mem_access_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ma_mem_access_ctrl_if.sv
// Data-memory bus between the MA-stage controller (master) and a multi-cycle memory (slave).
interface ma_mem_access_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/ma_mem_access_ctrl.sv
// MA-stage sequencer: turns load/store requests into req/ack memory transactions and stalls the pipe.
// Optional: define MA_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of silently aligning them.
module ma_mem_access_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [2:0]                  func_3,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 wdata,
  output logic                        stall,
  output logic [31:0]                 rdata,
  output logic                        bus_err,
  output logic                        misaligned_err,
  ma_mem_access_ctrl_if.master        dmem
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic             req, trap, timeout;
  logic             is_b, is_h;
  logic [3:0]       be_c;
  logic [31:0]      wd_c;

  assign req     = mem_read | mem_write;
  assign is_b    = (func_3 == 3'b000) || (func_3 == 3'b100);
  assign is_h    = (func_3 == 3'b001) || (func_3 == 3'b101);
  assign timeout = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_comb begin
    be_c = 4'b1111;
    wd_c = wdata;
    if (is_b) begin
      be_c = 4'b0001 << addr[1:0];
      wd_c = {4{wdata[7:0]}};
    end else if (is_h) begin
      be_c = 4'b0011 << {addr[1], 1'b0};
      wd_c = {2{wdata[15:0]}};
    end
  end

`ifdef MA_MISALIGN_TRAP_EN
  logic mis_q;
  assign trap = req & ((is_h & addr[0]) | (~is_b & ~is_h & (|addr[1:0])));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                          mis_q <= 1'b0;
    else if (state == S_IDLE && trap)   mis_q <= 1'b1;
    else if (state == S_DONE)           mis_q <= 1'b0;
  end
  assign misaligned_err = mis_q;
`else
  assign trap           = 1'b0;
  assign misaligned_err = 1'b0;
`endif

  // Lane select on the word returned by memory; codes outside B/H/BU/HU read as W.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'b0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'b0, h};
      default: fmt_load = w;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      S_IDLE: if (req) begin
        stall     = 1'b1;
        state_nxt = trap ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        stall = 1'b1;
        if (dmem.dmem_ack || timeout) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (RESET) stall = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      rdata           <= '0;
      bus_err         <= 1'b0;
      cnt             <= '0;
      f3_q            <= '0;
      lo_q            <= '0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          if (trap) begin
            rdata <= '0;
          end else begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= mem_write;
            dmem.dmem_addr  <= {addr[31:2], 2'b00};
            dmem.dmem_be    <= be_c;
            dmem.dmem_wdata <= wd_c;
            f3_q            <= func_3;
            lo_q            <= addr[1:0];
            cnt             <= '0;
          end
        end
        S_ACCESS: begin
          cnt <= cnt + 1'b1;
          // Ack beats a coincident timeout.
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            rdata         <= fmt_load(f3_q, lo_q, dmem.dmem_rdata);
          end else if (timeout) begin
            dmem.dmem_req <= 1'b0;
            rdata         <= '0;
            bus_err       <= 1'b1;
          end
        end
        S_DONE:  bus_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_mem_access_ctrl.sv
// Directed bench for ma_mem_access_ctrl (TIMEOUT=8); expectations follow MA_MISALIGN_TRAP_EN if defined.
module tb_ma_mem_access_ctrl;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        mem_read, mem_write;
  logic [2:0]  func_3;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        bus_err, misaligned_err;

  ma_mem_access_ctrl_if bus();

  ma_mem_access_ctrl #(.TIMEOUT(8), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .mem_read(mem_read), .mem_write(mem_write), .func_3(func_3),
    .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .bus_err(bus_err), .misaligned_err(misaligned_err),
    .dmem(bus)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0, n_fail = 0;
  int          st_cnt, acc_cnt;
  logic        done_ok, s_we, d_berr, d_merr, d_req;
  logic [31:0] s_addr, s_wd, d_rdata;
  logic [3:0]  s_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: ack_at = ACCESS cycle (1-based) carrying the ack, 0 = never ack.
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int ack_at, input logic [31:0] mword);
    logic seen;
    seen = 1'b0; st_cnt = 0; acc_cnt = 0; done_ok = 1'b0;
    s_we = 1'b0; s_addr = '0; s_be = '0; s_wd = '0;
    @(negedge CLK);
    mem_read = rd; mem_write = wr; func_3 = f3; addr = a; wdata = wd;
    for (int i = 0; i < 40 && !done_ok; i++) begin
      #1;
      if (stall) begin
        st_cnt++;
        if (bus.dmem_req) begin
          if (!seen) begin
            seen = 1'b1; s_we = bus.dmem_we; s_addr = bus.dmem_addr;
            s_be = bus.dmem_be; s_wd = bus.dmem_wdata;
          end
          acc_cnt++;
        end
        bus.dmem_ack   = bus.dmem_req && (acc_cnt == ack_at);
        bus.dmem_rdata = bus.dmem_ack ? mword : 32'h0;
        @(negedge CLK);
      end else begin
        d_rdata = rdata; d_berr = bus_err; d_merr = misaligned_err; d_req = bus.dmem_req;
        done_ok = 1'b1;
        bus.dmem_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    chk("done_reached", {31'b0, done_ok}, 32'd1);
  endtask

  initial begin
    RESET = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func_3 = 3'b010; addr = '0; wdata = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_stall_forced0", {31'b0, stall}, 32'd0);
    chk("rst_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'b0, bus.dmem_we}, 32'd0);
    chk("rst_dmem_addr", bus.dmem_addr, 32'h0);
    chk("rst_dmem_be", {28'b0, bus.dmem_be}, 32'h0);
    chk("rst_dmem_wdata", bus.dmem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst_mis_err", {31'b0, misaligned_err}, 32'd0);
    mem_read = 1'b0;
    @(negedge CLK); RESET = 1'b0;

    // LW 0x100, ack on 2nd ACCESS cycle
    run(1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    chk("lw_addr", s_addr, 32'h100);
    chk("lw_be", {28'b0, s_be}, 32'hF);
    chk("lw_we", {31'b0, s_we}, 32'd0);
    chk("lw_stall_cycles", st_cnt, 32'd3);
    chk("lw_rdata", d_rdata, 32'hDEADBEEF);
    chk("lw_req_dropped", {31'b0, d_req}, 32'd0);
    chk("lw_bus_err", {31'b0, d_berr}, 32'd0);
    @(negedge CLK); #1;
    chk("lw_rdata_hold", rdata, 32'hDEADBEEF);
    chk("idle_stall", {31'b0, stall}, 32'd0);

    // LB / LBU 0x103
    run(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF1234);
    chk("lb_be", {28'b0, s_be}, 32'h8);
    chk("lb_stall_cycles", st_cnt, 32'd2);
    chk("lb_rdata", d_rdata, 32'hFFFFFF80);
    run(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234);
    chk("lbu_rdata", d_rdata, 32'h00000080);

    // LH / LHU 0x102 (upper half)
    run(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF1234);
    chk("lh_be", {28'b0, s_be}, 32'hC);
    chk("lh_rdata", d_rdata, 32'hFFFF80FF);
    run(1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h80FF1234);
    chk("lhu_rdata", d_rdata, 32'h000080FF);

    // SH 0x202
    run(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h0);
    chk("sh_we", {31'b0, s_we}, 32'd1);
    chk("sh_be", {28'b0, s_be}, 32'hC);
    chk("sh_wdata", s_wd, 32'hABCDABCD);
    chk("sh_addr", s_addr, 32'h200);

    // SB 0x101 with read also high: write has priority
    run(1, 1, 3'b000, 32'h101, 32'h1234565A, 1, 32'h0);
    chk("sb_we", {31'b0, s_we}, 32'd1);
    chk("sb_be", {28'b0, s_be}, 32'h2);
    chk("sb_wdata", s_wd, 32'h5A5A5A5A);

    // Misaligned LW 0x101
    run(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h11223344);
`ifdef MA_MISALIGN_TRAP_EN
    chk("mis_stall_cycles", st_cnt, 32'd1);
    chk("mis_no_req", acc_cnt, 32'd0);
    chk("mis_err", {31'b0, d_merr}, 32'd1);
    chk("mis_rdata", d_rdata, 32'h0);
`else
    chk("mis_stall_cycles", st_cnt, 32'd2);
    chk("mis_addr", s_addr, 32'h100);
    chk("mis_be", {28'b0, s_be}, 32'hF);
    chk("mis_err", {31'b0, d_merr}, 32'd0);
    chk("mis_rdata", d_rdata, 32'h11223344);
`endif
    @(negedge CLK); #1;
    chk("mis_err_clears", {31'b0, misaligned_err}, 32'd0);

    // Timeout: no ack
    run(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
    chk("to_access_cycles", acc_cnt, 32'd8);
    chk("to_stall_cycles", st_cnt, 32'd9);
    chk("to_bus_err", {31'b0, d_berr}, 32'd1);
    chk("to_rdata", d_rdata, 32'h0);
    chk("to_req_dropped", {31'b0, d_req}, 32'd0);
    // late ack in IDLE is dropped
    @(negedge CLK); bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h55AA55AA; #1;
    chk("to_bus_err_clears", {31'b0, bus_err}, 32'd0);
    @(negedge CLK); bus.dmem_ack = 1'b0; #1;
    chk("late_ack_stall", {31'b0, stall}, 32'd0);
    chk("late_ack_rdata", rdata, 32'h0);

    // Reset mid-ACCESS, ack one cycle after release
    @(negedge CLK); mem_read = 1'b1; func_3 = 3'b010; addr = 32'h400;
    @(negedge CLK); #1;
    chk("rst_mid_req_up", {31'b0, bus.dmem_req}, 32'd1);
    @(negedge CLK); RESET = 1'b1; mem_read = 1'b0; #1;
    chk("rst_mid_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK); bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFEF00D; #1;
    chk("rst_ack_stall", {31'b0, stall}, 32'd0);
    @(negedge CLK); bus.dmem_ack = 1'b0; #1;
    chk("rst_ack_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_ack_rdata", rdata, 32'h0);
    chk("rst_ack_stall2", {31'b0, stall}, 32'd0);

    // FSM back in IDLE: a fresh load behaves normally
    run(1, 0, 3'b010, 32'h500, 32'h0, 1, 32'h0BADF00D);
    chk("post_rst_stall_cycles", st_cnt, 32'd2);
    chk("post_rst_rdata", d_rdata, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
